aes_key_gen: RTL and testbench
==============================

# aes_key_gen

Iterative AES-128 key-expansion engine. It latches a 128-bit cipher key on `init` and computes all 11 round keys, one round per clock. It stores the round keys internally and serves any one of them combinationally, selected by `round`. The S-box is not instantiated here: the SubWord lookup goes out through `sboxw` and comes back on `new_sboxw` from an external combinational `aes_sbox`, so the encipher datapath can share that S-box.

## Interface
No parameters (AES-128 only).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key`  in  128  cipher key; sampled only in the cycle `init` is accepted.
- `init`  in  1  start expansion; level-sampled, accepted only in IDLE.
- `round`  in  4  round-key index 0..10.
- `round_key`  out  128  stored key for `round`; combinational read.
- `ready`  out  1  high when idle and the key table is valid/stable.
- `sboxw`  out  32  word sent to the external S-box.
- `new_sboxw`  in  32  bytewise S-box substitution of `sboxw`; combinational return.

## Operation
- Key table: 11 x 128-bit registers `rk[0..10]`. Big-endian word order: w0 = bits [127:96].
- Round 0: `rk[0] = key`.
- Round i, for i = 1..10, with previous key words p0..p3:
  - `sboxw = p3`.
  - `t = RotWord(new_sboxw) ^ {rcon[i], 24'h0}`. RotWord is a left rotate by 8, so {b1,b2,b3,b0}.
  - `n0 = p0^t`, `n1 = p1^n0`, `n2 = p2^n1`, `n3 = p3^n2`.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- FSM:
  - IDLE: `ready=1`. If `init`=1, go to INIT.
  - INIT: write `rk[0]=key`, clear round counter to 1, `ready=0`, go to GEN.
  - GEN: write `rk[ctr]` from `rk[ctr-1]`, increment ctr. After writing `rk[10]`, go to IDLE.
- `init` held high across several cycles must not corrupt the expansion. It is ignored in INIT and GEN. If still high on return to IDLE, a new expansion starts.
- `round_key = rk[round]` for round ≤ 10; `128'h0` for round 11..15.
- `sboxw` = p3 of `rk[ctr-1]` in GEN; 0 otherwise.

## Timing
- Reset (async assert, sync release):
  - FSM to IDLE.
  - `ready=1`.
  - all `rk` cleared to 0, so `round_key`=0.
  - `sboxw`=0.
- `init` sampled at edge E0 (IDLE). `ready` goes low after E0.
- `rk[0]` is written at E1. `rk[i]` is written at edge E(i+1).
- `ready` returns high after E11, i.e. a latency of 11 cycles from acceptance.
- `round_key` follows `round` within the same cycle, with no pipeline.
- Reset mid-expansion aborts immediately: IDLE, `ready=1`, table cleared.
- `key` changes outside the accept cycle have no effect.
- Reading the table while `ready=0` returns partially updated content and is undefined for the user.

## Structure
- Shared package `aes_pkg`:
  - rcon table.
  - FSM state encoding (IDLE/INIT/GEN).
  - AES word/key width constants, shared with the cipher core.
- Sub-module `aes_sbox` (sboxw[31:0] → new_sboxw[31:0], 4 parallel byte lookups, purely combinational) lives outside this block. The bench and top level connect it.

## Test plan
- Reset: assert `reset`=0 for 2 cycles → `ready`=1 and `round_key`=0 for round 0.
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, `init` high 2 cycles, wait `ready`. Required round keys:
  - rk0 = key.
  - rk1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - rk2 = b692cf0b643dbdf1be9bc5006830b3fe.
  - rk5 = 3caaa3e8a99f9deb50f3af57adf622aa.
  - rk9 = 549932d1f08557681093ed9cbe2c974e.
  - rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - All 11 rounds are checked.
- Zero key re-init (no reset in between) → rk1 = 62636363626363636263636362636363, rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Handshake timing: `ready` low the cycle after `init` is accepted and high exactly 11 cycles after acceptance. A second `init` pulse during GEN is ignored and gives identical results.
- round = 11..15 → `round_key` = 0.
- Reset at cycle 5 of an expansion → immediate `ready`=1 and table zeroed. A subsequent full expansion gives the correct FIPS-197 keys.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-expansion FSM states and the round-constant table.
package aes_pkg;

  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_NR     = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_GEN
  } kg_state_e;

  // Round constant for rounds 1..10; the top byte of the Rcon word.
  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four parallel AES S-box byte lookups, purely combinational.
// Each byte is computed as the GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    // x^2 * x^4 * ... * x^128 = x^254, which also maps 0 to 0
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte of the incoming word independently.
  always_comb begin
    new_sboxw = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      new_sboxw[8*i +: 8] = sbox_byte(sboxw[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_gen.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry table,
// with SubWord served by an external S-box shared with the cipher datapath.
module aes_key_gen
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AES_KEY_W-1:0]  key,
  input  logic                  init,
  input  logic [3:0]            round,
  output logic [AES_KEY_W-1:0]  round_key,
  output logic                  ready,
  output logic [AES_WORD_W-1:0] sboxw,
  input  logic [AES_WORD_W-1:0] new_sboxw
);

  kg_state_e            state_q;
  logic [3:0]           ctr_q;
  logic                 ready_q;
  logic [AES_KEY_W-1:0] key_q;
  logic [AES_KEY_W-1:0] rk_q [0:AES_NR];

  logic [3:0]            prev_idx;
  logic [AES_KEY_W-1:0]  prev_rk;
  logic [AES_KEY_W-1:0]  next_rk_d;
  logic [AES_WORD_W-1:0] t_word;
  logic [AES_WORD_W-1:0] n0;
  logic [AES_WORD_W-1:0] n1;
  logic [AES_WORD_W-1:0] n2;
  logic [AES_WORD_W-1:0] n3;

  // Next round key from the previous table entry and the external S-box result.
  always_comb begin
    prev_idx  = ctr_q - 4'd1;
    prev_rk   = rk_q[prev_idx];
    sboxw     = (state_q == ST_GEN) ? prev_rk[31:0] : '0;
    t_word    = {new_sboxw[23:0], new_sboxw[31:24]} ^ {aes_rcon(ctr_q), 24'h000000};
    n0        = prev_rk[127:96] ^ t_word;
    n1        = prev_rk[95:64]  ^ n0;
    n2        = prev_rk[63:32]  ^ n1;
    n3        = prev_rk[31:0]   ^ n2;
    next_rk_d = {n0, n1, n2, n3};
  end

  // Combinational table read; indices beyond round 10 return zero.
  always_comb begin
    round_key = '0;
    if (round <= 4'(AES_NR)) round_key = rk_q[round];
  end

  assign ready = ready_q;

  // Expansion FSM: IDLE accepts init, INIT loads rk[0], GEN fills rk[1..10].
  // key is captured at acceptance so later key changes cannot reach rk[0] in INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      ctr_q   <= 4'd1;
      key_q   <= '0;
      for (int unsigned i = 0; i <= AES_NR; i++) rk_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            key_q   <= key;
            ready_q <= 1'b0;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          rk_q[0] <= key_q;
          ctr_q   <= 4'd1;
          state_q <= ST_GEN;
        end
        ST_GEN: begin
          rk_q[ctr_q] <= next_rk_d;
          if (ctr_q == 4'(AES_NR)) begin
            ctr_q   <= 4'd1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            ctr_q <= ctr_q + 4'd1;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_gen.sv
// Directed bench for aes_key_gen with FIPS-197 and zero-key expansion vectors.
module tb_aes_key_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] fips_rk [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  always #5 clk = ~clk;

  aes_key_gen dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .init      (init),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  aes_sbox u_sbox (
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one cycle at a time until ready, with a hard cycle bound.
  task automatic wait_ready();
    while (!ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic read_rk(input logic [3:0] r);
    @(negedge clk);
    round = r;
    #1;
  endtask

  // Full FIPS-197 expansion: init held two cycles, key scrambled after acceptance.
  task automatic run_fips(input string tag);
    @(negedge clk);
    key  = FIPS_KEY;
    init = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    check({tag, "_ready_low"}, ready, 1'b0);
    key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    @(posedge clk); #1;
    cyc = 1;
    check({tag, "_sboxw_r1"}, sboxw, 32'h0c0d0e0f);
    init = 1'b0;
    wait_ready();
    check({tag, "_latency"}, cyc, 11);
    for (int r = 0; r <= 10; r++) begin
      read_rk(4'(r));
      check($sformatf("%s_rk%0d", tag, r), round_key, fips_rk[r]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    init  = 1'b0;
    key   = '0;
    round = 4'd0;
    cyc   = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_rk0", round_key, '0);
    check("rst_sboxw", sboxw, '0);
    @(negedge clk);
    reset = 1'b1;

    run_fips("fips");

    for (int r = 11; r <= 15; r++) begin
      read_rk(4'(r));
      check($sformatf("oob_rk%0d", r), round_key, '0);
    end
    check("idle_ready", ready, 1'b1);
    check("idle_sboxw", sboxw, '0);

    // Zero-key re-init without reset, with a stray init pulse during GEN.
    @(negedge clk);
    key  = '0;
    init = 1'b1;
    @(posedge clk); #1;
    cyc  = 0;
    init = 1'b0;
    check("zero_ready_low", ready, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      cyc++;
    end
    init = 1'b1;
    @(posedge clk); #1;
    cyc++;
    init = 1'b0;
    wait_ready();
    check("zero_latency", cyc, 11);
    read_rk(4'd0);
    check("zero_rk0", round_key, '0);
    read_rk(4'd1);
    check("zero_rk1", round_key, 128'h62636363626363636263636362636363);
    read_rk(4'd10);
    check("zero_rk10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    @(posedge clk); #1;
    check("zero_stays_idle", ready, 1'b1);

    // Reset in the middle of an expansion.
    @(negedge clk);
    key  = FIPS_KEY;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_sboxw", sboxw, '0);
    round = 4'd10;
    #1;
    check("abort_rk10", round_key, '0);
    round = 4'd0;
    #1;
    check("abort_rk0", round_key, '0);
    @(negedge clk);
    reset = 1'b1;

    run_fips("refips");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
